// File: rtl/video_pkg.sv
// Shared types and default timing for the frame-buffer scan-out path.
package video_pkg;

  typedef logic [23:0] pixel_t;

  localparam int DEF_WIDTH    = 1024;
  localparam int DEF_HEIGHT   = 720;
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  // Per-pixel tag carried alongside the BRAM read so it lands with the data.
  typedef struct packed {
    logic        active;
    logic        in_fb;
    logic        hsync;
    logic        vsync;
    logic [10:0] h;
    logic [9:0]  v;
  } vid_tag_t;

  // Pixel-index bits plus one front/back buffer select bit.
  function automatic int fb_addr_width(input int w, input int h);
    return $clog2(w * h) + 1;
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Frame-buffer read port and renderer swap handshake of fb_scanout.
// Handshake: swap_req_in is a level held by the renderer; swap_ack_out is a one-cycle
// pulse the cycle after the request is taken in vertical blank; the renderer drops req after ack.
interface fb_scanout_if #(
  parameter int ADDR_W = video_pkg::fb_addr_width(video_pkg::DEF_WIDTH, video_pkg::DEF_HEIGHT)
) ();

  logic [ADDR_W-1:0] fb_addr_out;
  video_pkg::pixel_t fb_data_in;
  logic              swap_req_in;
  logic              swap_ack_out;
  logic              front_sel_out;

  modport master (
    output fb_addr_out,
    input  fb_data_in,
    input  swap_req_in,
    output swap_ack_out,
    output front_sel_out
  );

  modport slave (
    input  fb_addr_out,
    output fb_data_in,
    output swap_req_in,
    input  swap_ack_out,
    input  front_sel_out
  );

endinterface

// File: rtl/video_timing_gen.sv
// Raster counters (S0): h/v position, sync, visible and frame-buffer-window flags,
// plus line-end and frame-end strobes for the addressing logic.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int WIDTH    = 1024,
  parameter int HEIGHT   = 720
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [10:0] h_out,
  output logic [9:0]  v_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out,
  output logic        in_fb_out,
  output logic        line_end_out,
  output logic        frame_end_out
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(HT - 1);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_FB   = 11'(WIDTH);
  localparam logic [9:0]  V_LAST = 10'(VT - 1);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_FB   = 10'(HEIGHT);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        line_end, frame_end;

  always_comb begin
    line_end  = (h_q == H_LAST);
    frame_end = line_end && (v_q == V_LAST);
    h_d       = h_q + 11'd1;
    v_d       = v_q;
    if (line_end) begin
      h_d = '0;
      v_d = frame_end ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_out         = h_q;
  assign v_out         = v_q;
  assign hsync_out     = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vsync_out     = (v_q >= VS_BEG) && (v_q < VS_END);
  assign active_out    = (h_q < H_ACT) && (v_q < V_ACT);
  assign in_fb_out     = (h_q < H_FB) && (v_q < V_FB);
  assign line_end_out  = line_end;
  assign frame_end_out = frame_end;

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: addresses the BRAM, aligns timing with read data, double-buffer swap.
// Optional build macro FB_SCANOUT_TEST_PATTERN_EN adds test_pattern_in (h/v colour ramp).
module fb_scanout import video_pkg::*; #(
  parameter int     WIDTH      = DEF_WIDTH,
  parameter int     HEIGHT     = DEF_HEIGHT,
  parameter int     H_ACTIVE   = DEF_H_ACTIVE,
  parameter int     H_FP       = DEF_H_FP,
  parameter int     H_SYNC     = DEF_H_SYNC,
  parameter int     H_BP       = DEF_H_BP,
  parameter int     V_ACTIVE   = DEF_V_ACTIVE,
  parameter int     V_FP       = DEF_V_FP,
  parameter int     V_SYNC     = DEF_V_SYNC,
  parameter int     V_BP       = DEF_V_BP,
  parameter int     RD_LATENCY = 2,
  parameter pixel_t BG_COLOR   = 24'h000000
) (
  input  logic                clk_in,
  input  logic                rst_in,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  input  logic                test_pattern_in,
`endif
  fb_scanout_if.master        fb,
  output logic [10:0]         hcount_out,
  output logic [9:0]          vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                active_out,
  output pixel_t              pixel_out,
  output logic                frame_done_out
);

  localparam int AW = fb_addr_width(WIDTH, HEIGHT);
  localparam int LW = AW - 1;

  localparam logic [LW-1:0] ROW_STEP   = LW'(WIDTH);
  localparam logic [9:0]    V_ROW_LAST = 10'(HEIGHT - 1);
  localparam logic [9:0]    V_SAMPLE   = 10'(V_ACTIVE);
  localparam logic [10:0]   H_LAST_ACT = 11'(H_ACTIVE - 1);
  localparam logic [9:0]    V_LAST_ACT = 10'(V_ACTIVE - 1);

  logic [10:0] s0_h;
  logic [9:0]  s0_v;
  logic        s0_hsync, s0_vsync, s0_active, s0_in_fb, s0_line_end, s0_frame_end;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .WIDTH    (WIDTH),    .HEIGHT (HEIGHT)
  ) u_timing (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .h_out         (s0_h),
    .v_out         (s0_v),
    .hsync_out     (s0_hsync),
    .vsync_out     (s0_vsync),
    .active_out    (s0_active),
    .in_fb_out     (s0_in_fb),
    .line_end_out  (s0_line_end),
    .frame_end_out (s0_frame_end)
  );

  logic [LW-1:0]             row_base_q, row_base_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic                      front_sel_q, front_sel_d;
  logic                      ack_q, ack_d;
  vid_tag_t [RD_LATENCY:0]   pipe_q, pipe_d;
  logic [10:0]               hcount_q, hcount_d;
  logic [9:0]                vcount_q, vcount_d;
  logic                      hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  pixel_t                    pixel_q, pixel_d;
  logic                      frame_done_q, frame_done_d;
  logic                      fetch, swap_take;
  vid_tag_t                  tag;

  // Reads are limited to the visible part of the frame buffer, so any area beyond
  // the active raster is never fetched; row_base still steps per line.
  always_comb begin
    fetch     = s0_active && s0_in_fb;
    swap_take = (s0_h == 11'd0) && (s0_v == V_SAMPLE) && fb.swap_req_in;

    row_base_d = row_base_q;
    if (s0_frame_end)
      row_base_d = '0;
    else if (s0_line_end && (s0_v < V_ROW_LAST))
      row_base_d = row_base_q + ROW_STEP;

    addr_d = addr_q;
    if (fetch)
      addr_d = {front_sel_q, row_base_q + LW'(s0_h)};

    front_sel_d = front_sel_q ^ swap_take;
    ack_d       = swap_take;
  end

  // Tag stage i is visible i+1 cycles after S0; the last stage meets BRAM data.
  always_comb begin
    pipe_d = pipe_q;
    pipe_d[0].active = s0_active;
    pipe_d[0].in_fb  = s0_in_fb;
    pipe_d[0].hsync  = s0_hsync;
    pipe_d[0].vsync  = s0_vsync;
    pipe_d[0].h      = s0_h;
    pipe_d[0].v      = s0_v;
    for (int i = 1; i <= RD_LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    tag          = pipe_q[RD_LATENCY];
    hcount_d     = tag.h;
    vcount_d     = tag.v;
    hsync_d      = tag.hsync;
    vsync_d      = tag.vsync;
    active_d     = tag.active;
    frame_done_d = tag.active && (tag.h == H_LAST_ACT) && (tag.v == V_LAST_ACT);
    pixel_d      = '0;
    if (tag.active)
      pixel_d = tag.in_fb ? fb.fb_data_in : BG_COLOR;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    if (tag.active && test_pattern_in)
      pixel_d = {tag.h[7:0], tag.v[7:0], 8'h80};
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      row_base_q   <= '0;
      addr_q       <= '0;
      front_sel_q  <= 1'b0;
      ack_q        <= 1'b0;
      pipe_q       <= '0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      active_q     <= 1'b0;
      pixel_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_base_q   <= row_base_d;
      addr_q       <= addr_d;
      front_sel_q  <= front_sel_d;
      ack_q        <= ack_d;
      pipe_q       <= pipe_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      pixel_q      <= pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb.fb_addr_out   = addr_q;
  assign fb.swap_ack_out  = ack_q;
  assign fb.front_sel_out = front_sel_q;
  assign hcount_out       = hcount_q;
  assign vcount_out       = vcount_q;
  assign hsync_out        = hsync_q;
  assign vsync_out        = vsync_q;
  assign active_out       = active_q;
  assign pixel_out        = pixel_q;
  assign frame_done_out   = frame_done_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout with a small 12x7 raster and a 2-cycle BRAM model.
module tb_fb_scanout;

  localparam int AW = video_pkg::fb_addr_width(6, 4);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, active, frame_done;
  logic [23:0] pixel;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  fb_scanout_if #(.ADDR_W(AW)) fb_bus ();

  fb_scanout #(
    .WIDTH (6), .HEIGHT (4),
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .RD_LATENCY (2), .BG_COLOR (24'hABCDEF)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    .test_pattern_in(1'b0),
`endif
    .fb             (fb_bus.master),
    .hcount_out     (hcount),
    .vcount_out     (vcount),
    .hsync_out      (hsync),
    .vsync_out      (vsync),
    .active_out     (active),
    .pixel_out      (pixel),
    .frame_done_out (frame_done)
  );

  // Clock / cycle counter (cyc = posedges since reset release)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // BRAM model: two-cycle read, data = address without the buffer-select bit
  logic [AW-1:0] bram_a_q = '0;
  initial fb_bus.fb_data_in = '0;
  always @(posedge clk) begin
    bram_a_q          <= fb_bus.fb_addr_out;
    fb_bus.fb_data_in <= 24'(bram_a_q[AW-2:0]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fb_bus.swap_req_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h"},     32'(hcount), 0);
    check({tag, "_v"},     32'(vcount), 0);
    check({tag, "_hs"},    32'(hsync), 0);
    check({tag, "_vs"},    32'(vsync), 0);
    check({tag, "_act"},   32'(active), 0);
    check({tag, "_pix"},   32'(pixel), 0);
    check({tag, "_fd"},    32'(frame_done), 0);
    check({tag, "_addr"},  32'(fb_bus.fb_addr_out), 0);
    check({tag, "_ack"},   32'(fb_bus.swap_ack_out), 0);
    check({tag, "_sel"},   32'(fb_bus.front_sel_out), 0);
  endtask

  typedef struct {
    int          cyc;
    logic        swap_req;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, act;
    logic [23:0] pix;
    logic        fd;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  int ack_cnt, ack_cyc, fd_cnt, e;

  initial begin
    // outputs at cyc n describe raster position j = n-4 (j = h + 12*v)
    vecs[0]  = '{4,   1'b0, 11'd0,  10'd0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0};
    vecs[1]  = '{7,   1'b0, 11'd3,  10'd0, 1'b0, 1'b0, 1'b1, 24'h000003, 1'b0};
    vecs[2]  = '{10,  1'b0, 11'd6,  10'd0, 1'b0, 1'b0, 1'b1, 24'hABCDEF, 1'b0};
    vecs[3]  = '{11,  1'b0, 11'd7,  10'd0, 1'b0, 1'b0, 1'b1, 24'hABCDEF, 1'b0};
    vecs[4]  = '{12,  1'b0, 11'd8,  10'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[5]  = '{13,  1'b0, 11'd9,  10'd0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[6]  = '{14,  1'b0, 11'd10, 10'd0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[7]  = '{15,  1'b0, 11'd11, 10'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[8]  = '{19,  1'b0, 11'd3,  10'd1, 1'b0, 1'b0, 1'b1, 24'h000009, 1'b0};
    vecs[9]  = '{21,  1'b0, 11'd5,  10'd1, 1'b0, 1'b0, 1'b1, 24'h00000B, 1'b0};
    vecs[10] = '{45,  1'b0, 11'd5,  10'd3, 1'b0, 1'b0, 1'b1, 24'h000017, 1'b0};
    vecs[11] = '{47,  1'b0, 11'd7,  10'd3, 1'b0, 1'b0, 1'b1, 24'hABCDEF, 1'b1};
    vecs[12] = '{48,  1'b0, 11'd8,  10'd3, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[13] = '{52,  1'b0, 11'd0,  10'd4, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[14] = '{64,  1'b0, 11'd0,  10'd5, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
    vecs[15] = '{73,  1'b0, 11'd9,  10'd5, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0};
    vecs[16] = '{76,  1'b0, 11'd0,  10'd6, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
    vecs[17] = '{88,  1'b0, 11'd0,  10'd0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0};
    vecs[18] = '{103, 1'b0, 11'd3,  10'd1, 1'b0, 1'b0, 1'b1, 24'h000009, 1'b0};

    // Reset state
    fb_bus.swap_req_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");

    // Addressing: rows 0 and 1, held value outside the frame buffer
    do_reset();
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      if (n <= 6)       e = n - 1;
      else if (n <= 12) e = 5;
      else if (n <= 18) e = n - 7;
      else              e = 11;
      check($sformatf("addr_n%0d", n), 32'(fb_bus.fb_addr_out), 32'(e));
    end

    // Table-driven raster vectors
    do_reset();
    for (int i = 0; i < NV; i++) begin
      fb_bus.swap_req_in = vecs[i].swap_req;
      wait_cyc(vecs[i].cyc);
      check($sformatf("v%0d_h", i),   32'(hcount),     32'(vecs[i].h));
      check($sformatf("v%0d_v", i),   32'(vcount),     32'(vecs[i].v));
      check($sformatf("v%0d_hs", i),  32'(hsync),      32'(vecs[i].hs));
      check($sformatf("v%0d_vs", i),  32'(vsync),      32'(vecs[i].vs));
      check($sformatf("v%0d_act", i), 32'(active),     32'(vecs[i].act));
      check($sformatf("v%0d_pix", i), 32'(pixel),      32'(vecs[i].pix));
      check($sformatf("v%0d_fd", i),  32'(frame_done), 32'(vecs[i].fd));
    end

    // frame_done over three frames
    do_reset();
    fd_cnt = 0;
    while (cyc < 260) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        check("fd_h", 32'(hcount), 7);
        check("fd_v", 32'(vcount), 3);
        check("fd_cyc", 32'(cyc), 32'(47 + 84 * fd_cnt));
        fd_cnt++;
      end
    end
    check("fd_count", 32'(fd_cnt), 3);

    // Swap requested during row 2, dropped after ack
    do_reset();
    ack_cnt = 0;
    ack_cyc = -1;
    while (cyc < 196) begin
      @(negedge clk);
      if (cyc == 30) fb_bus.swap_req_in = 1'b1;
      if (fb_bus.swap_ack_out === 1'b1) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = cyc;
        fb_bus.swap_req_in = 1'b0;
      end
      if (cyc == 48) check("swap_sel_before", 32'(fb_bus.front_sel_out), 0);
      if (cyc == 49) check("swap_sel_after",  32'(fb_bus.front_sel_out), 1);
      if (cyc == 84) check("swap_addr_hold",  32'(fb_bus.fb_addr_out), 23);
      if (cyc == 85) check("swap_addr_msb",   32'(fb_bus.fb_addr_out), 32);
    end
    check("swap_ack_count", 32'(ack_cnt), 1);
    check("swap_ack_cyc",   32'(ack_cyc), 49);
    check("swap_sel_final", 32'(fb_bus.front_sel_out), 1);
    check("pre_rst_pix",    32'(pixel), 12);
    check("pre_rst_act",    32'(active), 1);

    // Reset mid-frame at (h=4, v=2)
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("restart_addr", 32'(fb_bus.fb_addr_out), 0);
        check("restart_sel",  32'(fb_bus.front_sel_out), 0);
      end
      if (n < 4) begin
        check($sformatf("restart_act_n%0d", n), 32'(active), 0);
        check($sformatf("restart_pix_n%0d", n), 32'(pixel), 0);
      end else begin
        check("restart_first_act", 32'(active), 1);
        check("restart_first_h",   32'(hcount), 0);
        check("restart_first_v",   32'(vcount), 0);
      end
    end

    // Request raised after the sample point waits a full frame
    do_reset();
    ack_cnt = 0;
    ack_cyc = -1;
    while (cyc < 250) begin
      @(negedge clk);
      if (cyc == 61) fb_bus.swap_req_in = 1'b1;
      if (fb_bus.swap_ack_out === 1'b1) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = cyc;
        fb_bus.swap_req_in = 1'b0;
      end
      if (cyc == 132) check("late_sel_before", 32'(fb_bus.front_sel_out), 0);
      if (cyc == 133) check("late_sel_after",  32'(fb_bus.front_sel_out), 1);
    end
    check("late_ack_count", 32'(ack_cnt), 1);
    check("late_ack_cyc",   32'(ack_cyc), 133);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
